prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Boot-time program loader that sits directly upstream of the rv32i single-cycle core.
- Consumes a byte stream (e.g. from a UART RX) and packs little-endian 32-bit words.
- Writes the words into instruction BRAM or data BRAM through their write ports, then releases the core (PC stall, data-BRAM port ownership).
- Replaces the bench-driven BRAM preload with synthesizable hardware for the Zybo Z7-20.

Parameters:
- ADDR_WIDTH, 10: BRAM write-address width in bytes.
- DATA_WIDTH, 32: word width.
- MAX_WORDS, 256: maximum words per frame; MAX_WORDS*4 must be <= 2^ADDR_WIDTH.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- in_byte  in  8  stream byte.
- in_valid  in  1  in_byte is valid.
- in_ready  out  1  loader accepts in_byte this cycle.
- i_w_addr  out  ADDR_WIDTH  instruction BRAM write byte address.
- i_w_dat  out  DATA_WIDTH  instruction BRAM write data.
- i_w_enb  out  1  instruction BRAM write enable (1-cycle pulse).
- d_w_addr  out  ADDR_WIDTH  data BRAM write byte address.
- d_w_dat  out  DATA_WIDTH  data BRAM write data.
- d_w_enb  out  1  data BRAM write enable (1-cycle pulse).
- cpu_stall  out  1  drives PC stall; 1 while loading.
- d_bram_init_done  out  1  1 = core owns the data BRAM write port.
- busy  out  1  a frame is in progress.
- err  out  1  sticky error flag.

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high. All outputs are registered.
- Reset values:
  - in_ready=1, cpu_stall=1, d_bram_init_done=0, err=0, busy=0.
  - All w_enb=0; all addresses and data=0; state=IDLE.
- Handshake: a byte is consumed on any clk edge with in_valid & in_ready. in_ready=0 only in WRITE and ERROR.
- Command bytes:
  - 0xA5 = load IMEM frame.
  - 0x5A = load DMEM frame.
  - 0xC3 = run.
  - 0x0F = halt.
- Frame format: cmd, cnt_lo, cnt_hi, then cnt×4 data bytes. Each word is little-endian (first byte → bits 7:0).
- State IDLE (cpu_stall=1, d_bram_init_done=0):
  - 0xA5 or 0x5A → latch target, go to CNT_LO.
  - 0xC3 → RUN.
  - 0x0F → stay in IDLE.
  - Any other byte: one-cycle err_pulse internally, set err, stay in IDLE.
- State CNT_LO: next byte → cnt[7:0], go to CNT_HI.
- State CNT_HI: next byte → cnt[15:8].
  - cnt==0 → IDLE, no writes.
  - cnt>MAX_WORDS → ERROR.
  - Otherwise clear word index and byte index, go to DATA.
- State DATA (busy=1): each accepted byte is shifted into the word register. On the 4th byte go to WRITE.
- State WRITE (one cycle, in_ready=0):
  - Assert the selected w_enb for exactly one cycle, with w_addr = index*4 and w_dat = packed word. The non-selected port's enb stays 0.
  - Index increments. If index reaches cnt → IDLE, else → DATA.
  - Latency: w_enb is high in the cycle after the edge that accepted the 4th byte.
- State RUN (cpu_stall=0, d_bram_init_done=1):
  - in_ready=1 and bytes are discarded, except 0x0F → IDLE. cpu_stall=1 and d_bram_init_done=0 take effect from the next cycle.
- State ERROR: cpu_stall=1, in_ready=0, err=1. Only rst exits.
- err is also sticky from IDLE; only rst clears it.
- Addressing: addresses never wrap, guaranteed by the MAX_WORDS check. A word at index MAX_WORDS-1 writes at byte address (MAX_WORDS-1)*4.
- in_valid low mid-frame: the FSM waits indefinitely with partial word and count held. There is no timeout.
- rst mid-frame: everything returns to reset values in the next cycle. No partial word is written, and BRAM contents already written are untouched.
- Frames may be repeated. A later frame overwrites from address 0.

Decomposition:
- Shared include rv32i_loader.vh holds the command byte constants (LDR_CMD_IMEM, LDR_CMD_DMEM, LDR_CMD_RUN, LDR_CMD_HALT) and the state encodings (IDLE, CNT_LO, CNT_HI, DATA, WRITE, RUN, ERROR).
- One sub-module, byte_packer, is natural: a 4-byte little-endian shift/accumulate register with byte counter, load/clear inputs and a word_full output.

Test Plan:
- IMEM frame A5 02 00 13 05 50 00 93 02 50 00 → i_w_enb pulses twice:
  - addr 0x000 dat 0x00500513.
  - addr 0x004 dat 0x00500293.
  - d_w_enb stays 0; cpu_stall stays 1.
- DMEM frame 5A 01 00 01 00 00 00 then C3 → d_w_enb pulse at addr 0x000 dat 0x00000001. After C3: cpu_stall=0, d_bram_init_done=1 next cycle.
- Count 0 and count overflow:
  - A5 00 00 → returns to IDLE with no write pulses.
  - A5 01 01 (257>256) → ERROR: err=1, in_ready=0.
  - rst → all reset values.
- in_valid gaps of 3 cycles between every byte of a one-word frame → single correct write. in_ready drops exactly one cycle after the 4th byte.
- RUN then 0x0F → cpu_stall returns to 1, d_bram_init_done to 0. A following invalid byte 0x77 in IDLE → err=1, state stays IDLE.
- rst asserted after 2 data bytes of a word → no w_enb pulse. A new frame after reset writes at address 0x000.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-time program loader: command bytes,
// FSM state encoding and the BRAM target selector.
package prog_loader_pkg;

    localparam logic [7:0] LDR_CMD_IMEM = 8'hA5;
    localparam logic [7:0] LDR_CMD_DMEM = 8'h5A;
    localparam logic [7:0] LDR_CMD_RUN  = 8'hC3;
    localparam logic [7:0] LDR_CMD_HALT = 8'h0F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CNT_LO,
        ST_CNT_HI,
        ST_DATA,
        ST_WRITE,
        ST_RUN,
        ST_ERROR
    } state_t;

    typedef enum logic {
        TGT_IMEM,
        TGT_DMEM
    } target_t;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Little-endian 4-byte word accumulator. The first byte loaded after a
// clear lands in bits 7:0. word_next/word_full show the word including the
// byte being loaded this cycle, so the caller can register it directly.
module prog_loader_byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        load,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_next,
    output logic        word_full
);

    logic [31:0] word_q, word_d;
    logic [1:0]  count_q, count_d;

    // Place the incoming byte at the lane selected by the byte counter.
    always_comb begin
        word_next = word_q;
        word_next[{count_q, 3'b000} +: 8] = byte_in;
        word_full = load && (count_q == 2'd3);
        word_d    = word_q;
        count_d   = count_q;
        if (clear) begin
            word_d  = '0;
            count_d = '0;
        end else if (load) begin
            word_d  = word_next;
            count_d = count_q + 2'd1;
        end
    end

    // Word and byte-counter registers; the counter wraps to 0 on the 4th byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q  <= '0;
            count_q <= '0;
        end else begin
            word_q  <= word_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: parses a byte stream of command frames, packs
// little-endian words into instruction or data BRAM, then releases the core.
// Every output is registered and computed from the next state.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WORDS  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_byte,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] i_w_addr,
    output logic [DATA_WIDTH-1:0] i_w_dat,
    output logic                  i_w_enb,
    output logic [ADDR_WIDTH-1:0] d_w_addr,
    output logic [DATA_WIDTH-1:0] d_w_dat,
    output logic                  d_w_enb,
    output logic                  cpu_stall,
    output logic                  d_bram_init_done,
    output logic                  busy,
    output logic                  err
);

    state_t  state_q, state_d;
    target_t target_q, target_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] idx_q, idx_d;

    logic                  in_ready_q, in_ready_d;
    logic                  cpu_stall_q, cpu_stall_d;
    logic                  init_done_q, init_done_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;
    logic                  i_w_enb_q, i_w_enb_d;
    logic                  d_w_enb_q, d_w_enb_d;
    logic [ADDR_WIDTH-1:0] i_w_addr_q, i_w_addr_d;
    logic [ADDR_WIDTH-1:0] d_w_addr_q, d_w_addr_d;
    logic [DATA_WIDTH-1:0] i_w_dat_q, i_w_dat_d;
    logic [DATA_WIDTH-1:0] d_w_dat_q, d_w_dat_d;

    logic        accept;
    logic        err_pulse;
    logic        pk_clear;
    logic        pk_load;
    logic [31:0] pk_word;
    logic        pk_full;

    assign accept = in_valid && in_ready_q;

    prog_loader_byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (pk_clear),
        .load      (pk_load),
        .byte_in   (in_byte),
        .word_next (pk_word),
        .word_full (pk_full)
    );

    // Next-state logic for the frame parser and run/halt control.
    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        err_pulse = 1'b0;
        pk_clear  = 1'b0;
        pk_load   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (in_byte)
                        LDR_CMD_IMEM: begin
                            target_d = TGT_IMEM;
                            state_d  = ST_CNT_LO;
                        end
                        LDR_CMD_DMEM: begin
                            target_d = TGT_DMEM;
                            state_d  = ST_CNT_LO;
                        end
                        LDR_CMD_RUN:  state_d = ST_RUN;
                        LDR_CMD_HALT: state_d = ST_IDLE;
                        default:      err_pulse = 1'b1;
                    endcase
                end
            end
            ST_CNT_LO: begin
                if (accept) begin
                    cnt_d   = {8'h00, in_byte};
                    state_d = ST_CNT_HI;
                end
            end
            ST_CNT_HI: begin
                if (accept) begin
                    cnt_d = {in_byte, cnt_q[7:0]};
                    if (cnt_d == 16'd0) begin
                        state_d = ST_IDLE;
                    end else if (cnt_d > 16'(MAX_WORDS)) begin
                        state_d = ST_ERROR;
                    end else begin
                        idx_d    = '0;
                        pk_clear = 1'b1;
                        state_d  = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    pk_load = 1'b1;
                    if (pk_full) begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                idx_d   = idx_q + 16'd1;
                state_d = (idx_d == cnt_q) ? ST_IDLE : ST_DATA;
            end
            ST_RUN: begin
                if (accept && (in_byte == LDR_CMD_HALT)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Registered outputs derived from the state being entered, so the write
    // pulse appears in the cycle right after the 4th data byte is accepted.
    always_comb begin
        in_ready_d  = !((state_d == ST_WRITE) || (state_d == ST_ERROR));
        cpu_stall_d = (state_d != ST_RUN);
        init_done_d = (state_d == ST_RUN);
        busy_d      = (state_d == ST_CNT_LO) || (state_d == ST_CNT_HI) ||
                      (state_d == ST_DATA)   || (state_d == ST_WRITE);
        err_d       = err_q || err_pulse || (state_d == ST_ERROR);
        i_w_enb_d   = (state_d == ST_WRITE) && (target_q == TGT_IMEM);
        d_w_enb_d   = (state_d == ST_WRITE) && (target_q == TGT_DMEM);
        i_w_addr_d  = i_w_addr_q;
        i_w_dat_d   = i_w_dat_q;
        d_w_addr_d  = d_w_addr_q;
        d_w_dat_d   = d_w_dat_q;
        if (i_w_enb_d) begin
            i_w_addr_d = ADDR_WIDTH'({idx_q, 2'b00});
            i_w_dat_d  = DATA_WIDTH'(pk_word);
        end
        if (d_w_enb_d) begin
            d_w_addr_d = ADDR_WIDTH'({idx_q, 2'b00});
            d_w_dat_d  = DATA_WIDTH'(pk_word);
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            target_q    <= TGT_IMEM;
            cnt_q       <= '0;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            cpu_stall_q <= 1'b1;
            init_done_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            i_w_enb_q   <= 1'b0;
            d_w_enb_q   <= 1'b0;
            i_w_addr_q  <= '0;
            i_w_dat_q   <= '0;
            d_w_addr_q  <= '0;
            d_w_dat_q   <= '0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            in_ready_q  <= in_ready_d;
            cpu_stall_q <= cpu_stall_d;
            init_done_q <= init_done_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            i_w_enb_q   <= i_w_enb_d;
            d_w_enb_q   <= d_w_enb_d;
            i_w_addr_q  <= i_w_addr_d;
            i_w_dat_q   <= i_w_dat_d;
            d_w_addr_q  <= d_w_addr_d;
            d_w_dat_q   <= d_w_dat_d;
        end
    end

    assign in_ready         = in_ready_q;
    assign cpu_stall        = cpu_stall_q;
    assign d_bram_init_done = init_done_q;
    assign busy             = busy_q;
    assign err              = err_q;
    assign i_w_enb          = i_w_enb_q;
    assign d_w_enb          = d_w_enb_q;
    assign i_w_addr         = i_w_addr_q;
    assign i_w_dat          = i_w_dat_q;
    assign d_w_addr         = d_w_addr_q;
    assign d_w_dat          = d_w_dat_q;

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: scenario tasks plus a write monitor that
// checks every BRAM write pulse against an expected-write queue built from
// the frame contents (address = word index * 4, little-endian packing).
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_byte = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [9:0]  i_w_addr;
    logic [31:0] i_w_dat;
    logic        i_w_enb;
    logic [9:0]  d_w_addr;
    logic [31:0] d_w_dat;
    logic        d_w_enb;
    logic        cpu_stall;
    logic        d_bram_init_done;
    logic        busy;
    logic        err;

    int ntests = 0;
    int nfail  = 0;

    typedef struct {
        bit          dmem;
        logic [9:0]  addr;
        logic [31:0] dat;
    } wr_t;

    wr_t exp_q[$];

    prog_loader #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .MAX_WORDS(256)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_byte          (in_byte),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .i_w_addr         (i_w_addr),
        .i_w_dat          (i_w_dat),
        .i_w_enb          (i_w_enb),
        .d_w_addr         (d_w_addr),
        .d_w_dat          (d_w_dat),
        .d_w_enb          (d_w_enb),
        .cpu_stall        (cpu_stall),
        .d_bram_init_done (d_bram_init_done),
        .busy             (busy),
        .err              (err)
    );

    always #5 clk = ~clk;

    // Every write pulse must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (i_w_enb === 1'b1 || d_w_enb === 1'b1) begin
            ntests++;
            if (i_w_enb === 1'b1 && d_w_enb === 1'b1) begin
                nfail++;
                $display("[TB] FAIL both_enb: i_w_enb=%b d_w_enb=%b, required only one", i_w_enb, d_w_enb);
            end else if (exp_q.size() == 0) begin
                nfail++;
                $display("[TB] FAIL unexpected_write: i_enb=%b d_enb=%b i_addr=%h d_addr=%h, required no write",
                         i_w_enb, d_w_enb, i_w_addr, d_w_addr);
            end else begin
                wr_t e;
                bit  got_d;
                logic [9:0]  got_a;
                logic [31:0] got_w;
                e     = exp_q.pop_front();
                got_d = (d_w_enb === 1'b1);
                got_a = got_d ? d_w_addr : i_w_addr;
                got_w = got_d ? d_w_dat : i_w_dat;
                if (got_d !== e.dmem || got_a !== e.addr || got_w !== e.dat) begin
                    nfail++;
                    $display("[TB] FAIL write: got dmem=%0d addr=%h dat=%h, required dmem=%0d addr=%h dat=%h",
                             got_d, got_a, got_w, e.dmem, e.addr, e.dat);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    // Offer one byte after 'gap' idle cycles and return #1 after acceptance.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int budget = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_byte  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 50) begin
            ntests++;
            nfail++;
            $display("[TB] FAIL accept_timeout: in_ready=%b, required 1 within 50 cycles", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Build a frame of random words, record the writes it must produce.
    task automatic send_frame(input bit dmem, input int n, input int max_gap);
        logic [31:0] w;
        send_byte(dmem ? 8'h5A : 8'hA5, $urandom_range(max_gap, 0));
        send_byte(8'(n), $urandom_range(max_gap, 0));
        send_byte(8'(n >> 8), $urandom_range(max_gap, 0));
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            exp_q.push_back('{dmem: dmem, addr: 10'(i * 4), dat: w});
            for (int k = 0; k < 4; k++) begin
                send_byte(w[k*8 +: 8], $urandom_range(max_gap, 0));
            end
        end
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        ntests++;
        if ({in_ready, cpu_stall, d_bram_init_done, err, busy} !== 5'b11000) begin
            nfail++;
            $display("[TB] FAIL reset_flags: ready/stall/done/err/busy=%b, required 11000",
                     {in_ready, cpu_stall, d_bram_init_done, err, busy});
        end
        ntests++;
        if ({i_w_enb, d_w_enb} !== 2'b00) begin
            nfail++;
            $display("[TB] FAIL reset_enb: %b, required 00", {i_w_enb, d_w_enb});
        end
        ntests++;
        if (i_w_addr !== 10'd0 || d_w_addr !== 10'd0 || i_w_dat !== 32'd0 || d_w_dat !== 32'd0) begin
            nfail++;
            $display("[TB] FAIL reset_bus: i_addr=%h d_addr=%h i_dat=%h d_dat=%h, required all 0",
                     i_w_addr, d_w_addr, i_w_dat, d_w_dat);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_imem_frame();
        logic [7:0] frame [11];
        frame = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h02, 8'h50, 8'h00};
        do_reset();
        exp_q.push_back('{dmem: 1'b0, addr: 10'h000, dat: 32'h00500513});
        exp_q.push_back('{dmem: 1'b0, addr: 10'h004, dat: 32'h00500293});
        for (int i = 0; i < 11; i++) send_byte(frame[i], 0);
        settle();
        ntests++;
        if (exp_q.size() != 0) begin
            nfail++;
            $display("[TB] FAIL imem_writes: %0d writes missing, required 0", exp_q.size());
        end
        ntests++;
        if (cpu_stall !== 1'b1 || busy !== 1'b0) begin
            nfail++;
            $display("[TB] FAIL imem_after: stall=%b busy=%b, required 1 0", cpu_stall, busy);
        end
    endtask

    task automatic test_dmem_run();
        logic [7:0] frame [7];
        frame = '{8'h5A, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
        do_reset();
        exp_q.push_back('{dmem: 1'b1, addr: 10'h000, dat: 32'h00000001});
        for (int i = 0; i < 7; i++) send_byte(frame[i], 0);
        settle();
        ntests++;
        if (exp_q.size() != 0 || cpu_stall !== 1'b1) begin
            nfail++;
            $display("[TB] FAIL dmem_writes: missing=%0d stall=%b, required 0 1", exp_q.size(), cpu_stall);
        end
        send_byte(8'hC3, 0);
        ntests++;
        if (cpu_stall !== 1'b0 || d_bram_init_done !== 1'b1) begin
            nfail++;
            $display("[TB] FAIL run_release: stall=%b done=%b, required 0 1", cpu_stall, d_bram_init_done);
        end
    endtask

    // Continues from RUN left by test_dmem_run.
    task automatic test_halt_err();
        send_byte(8'hA5, 0);
        ntests++;
        if (cpu_stall !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            nfail++;
            $display("[TB] FAIL run_discard: stall=%b busy=%b ready=%b, required 0 0 1", cpu_stall, busy, in_ready);
        end
        send_byte(8'h0F, 0);
        ntests++;
        if (cpu_stall !== 1'b1 || d_bram_init_done !== 1'b0) begin
            nfail++;
            $display("[TB] FAIL halt: stall=%b done=%b, required 1 0", cpu_stall, d_bram_init_done);
        end
        send_byte(8'h77, 0);
        ntests++;
        if (err !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0) begin
            nfail++;
            $display("[TB] FAIL bad_cmd: err=%b ready=%b busy=%b, required 1 1 0", err, in_ready, busy);
        end
        send_frame(1'b0, 1, 0);
        settle();
        ntests++;
        if (exp_q.size() != 0 || err !== 1'b1) begin
            nfail++;
            $display("[TB] FAIL idle_after_err: missing=%0d err=%b, required 0 1", exp_q.size(), err);
        end
    endtask

    task automatic test_count_edges();
        do_reset();
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        ntests++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || err !== 1'b0) begin
            nfail++;
            $display("[TB] FAIL count_zero: busy=%b ready=%b err=%b, required 0 1 0", busy, in_ready, err);
        end
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        ntests++;
        if (busy !== 1'b1 || err !== 1'b0) begin
            nfail++;
            $display("[TB] FAIL count_max: busy=%b err=%b, required 1 0", busy, err);
        end
        do_reset();
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        ntests++;
        if (err !== 1'b1 || in_ready !== 1'b0 || cpu_stall !== 1'b1) begin
            nfail++;
            $display("[TB] FAIL count_overflow: err=%b ready=%b stall=%b, required 1 0 1", err, in_ready, cpu_stall);
        end
        settle();
        ntests++;
        if (err !== 1'b1 || in_ready !== 1'b0) begin
            nfail++;
            $display("[TB] FAIL error_hold: err=%b ready=%b, required 1 0", err, in_ready);
        end
        do_reset();
        #1;
        ntests++;
        if (err !== 1'b0 || in_ready !== 1'b1 || cpu_stall !== 1'b1) begin
            nfail++;
            $display("[TB] FAIL error_reset: err=%b ready=%b stall=%b, required 0 1 1", err, in_ready, cpu_stall);
        end
    endtask

    task automatic test_gaps();
        logic [31:0] w;
        do_reset();
        w = $urandom;
        exp_q.push_back('{dmem: 1'b1, addr: 10'h000, dat: w});
        send_byte(8'h5A, 3);
        send_byte(8'h01, 3);
        send_byte(8'h00, 3);
        for (int k = 0; k < 3; k++) send_byte(w[k*8 +: 8], 3);
        ntests++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            nfail++;
            $display("[TB] FAIL gap_wait: ready=%b busy=%b, required 1 1", in_ready, busy);
        end
        send_byte(w[31:24], 3);
        ntests++;
        if (in_ready !== 1'b0 || d_w_enb !== 1'b1) begin
            nfail++;
            $display("[TB] FAIL gap_write_cycle: ready=%b d_enb=%b, required 0 1", in_ready, d_w_enb);
        end
        @(posedge clk);
        #1;
        ntests++;
        if (in_ready !== 1'b1 || d_w_enb !== 1'b0) begin
            nfail++;
            $display("[TB] FAIL gap_after_write: ready=%b d_enb=%b, required 1 0", in_ready, d_w_enb);
        end
        settle();
        ntests++;
        if (exp_q.size() != 0) begin
            nfail++;
            $display("[TB] FAIL gap_writes: %0d missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        ntests++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || i_w_enb !== 1'b0 || err !== 1'b0) begin
            nfail++;
            $display("[TB] FAIL midframe_reset: busy=%b ready=%b i_enb=%b err=%b, required 0 1 0 0",
                     busy, in_ready, i_w_enb, err);
        end
        @(negedge clk);
        rst = 1'b0;
        send_frame(1'b0, 1, 0);
        settle();
        ntests++;
        if (exp_q.size() != 0) begin
            nfail++;
            $display("[TB] FAIL midframe_refill: %0d missing, required 0", exp_q.size());
        end
    endtask

    // Random back-to-back frames to both memories plus one maximum-size frame.
    task automatic test_back_to_back();
        do_reset();
        for (int f = 0; f < 6; f++) begin
            send_frame(1'($urandom_range(1, 0)), $urandom_range(8, 1), (f % 2 == 0) ? 0 : 2);
        end
        send_frame(1'b0, 256, 0);
        settle();
        ntests++;
        if (exp_q.size() != 0 || err !== 1'b0) begin
            nfail++;
            $display("[TB] FAIL back_to_back: missing=%0d err=%b, required 0 0", exp_q.size(), err);
        end
    endtask

    initial begin
        test_reset();
        test_imem_frame();
        test_dmem_run();
        test_halt_err();
        test_count_edges();
        test_gaps();
        test_reset_midframe();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    // Global safety net so the bench never hangs.
    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation time limit reached, required completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
